// File: rtl/latch_bank_arbiter.sv
// ============================================================================
// latch_bank_arbiter: round-robin arbiter driving a shared level-sensitive latch
// Revision: 1.0
// ============================================================================
`default_nettype none

module latch_bank_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int OPEN_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    latch_en,
  output logic [WIDTH-1:0]        latch_d,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(OPEN_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_OPEN  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   ack_q;
  logic              latch_en_q;
  logic [WIDTH-1:0]  latch_d_q;
  logic              busy_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gidx_q;
  logic [CW-1:0]     cnt_q;

  logic              sel_valid_d;
  logic [PW-1:0]     sel_idx_d;
  logic [WIDTH-1:0]  sel_data_d;
  logic [PW-1:0]     cand;

  // Scan downward in priority order so the lowest offset from ptr wins last.
  always_comb begin
    sel_valid_d = 1'b0;
    sel_idx_d   = '0;
    sel_data_d  = '0;
    cand        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (req[cand]) begin
        sel_valid_d = 1'b1;
        sel_idx_d   = cand;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (PW'(k) == sel_idx_d) begin
        sel_data_d = wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      latch_en_q <= 1'b0;
      latch_d_q  <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      gidx_q     <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid_d) begin
            state_q   <= S_SETUP;
            grant_q   <= NREQ'(1) << sel_idx_d;
            gidx_q    <= sel_idx_d;
            latch_d_q <= sel_data_d;
            busy_q    <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q    <= S_OPEN;
          latch_en_q <= 1'b1;
          cnt_q      <= '0;
        end
        S_OPEN: begin
          if (cnt_q == CNT_LAST) begin
            state_q    <= S_HOLD;
            latch_en_q <= 1'b0;
            ack_q      <= grant_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign latch_en = latch_en_q;
  assign latch_d  = latch_d_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
// ============================================================================
// tb_latch_bank_arbiter: timeline model plus directed vectors for two latch widths of open time
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_latch_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  grant_a, ack_a, latch_d_a;
  logic        latch_en_a, busy_a;
  logic [3:0]  grant_b, ack_b, latch_d_b;
  logic        latch_en_b, busy_b;
  logic [3:0]  lat_a;
  bit          started;

  int checks = 0;
  int errors = 0;

  // Model state: a transaction is described only by its start edge, winner and data.
  int          cyc;
  bit          m_act   [2];
  int          m_start [2];
  int          m_idx   [2];
  int          m_ptr   [2];
  logic [3:0]  m_data  [2];
  int          ocs     [2] = '{1, 4};

  logic [3:0]  rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0]  rr_d [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};

  latch_bank_arbiter #(.NREQ(4), .WIDTH(4), .OPEN_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant_a), .ack(ack_a), .latch_en(latch_en_a), .latch_d(latch_d_a), .busy(busy_a)
  );

  latch_bank_arbiter #(.NREQ(4), .WIDTH(4), .OPEN_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant_b), .ack(ack_b), .latch_en(latch_en_b), .latch_d(latch_d_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Behavioural model of the external positive-level latch.
  initial begin
    lat_a = 4'h0;
    forever begin
      @(latch_en_a or latch_d_a);
      if (latch_en_a) lat_a = latch_d_a;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    cyc = 0;
    for (int n = 0; n < 2; n++) begin
      m_act[n] = 1'b0; m_start[n] = 0; m_idx[n] = 0; m_ptr[n] = 0; m_data[n] = 4'h0;
    end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int n = 0; n < 2; n++) begin
          m_act[n] = 1'b0; m_ptr[n] = 0; m_data[n] = 4'h0;
        end
      end else begin
        cyc++;
        for (int n = 0; n < 2; n++) begin
          if (!m_act[n] || (cyc - m_start[n] >= ocs[n] + 3)) begin
            bit found;
            int win;
            found = 1'b0;
            win   = 0;
            m_act[n] = 1'b0;
            for (int k = 0; k < 4; k++) begin
              if (!found && (((req >> ((m_ptr[n] + k) % 4)) & 4'd1) != 4'd0)) begin
                found = 1'b1;
                win   = (m_ptr[n] + k) % 4;
              end
            end
            if (found) begin
              m_act[n]   = 1'b1;
              m_start[n] = cyc;
              m_idx[n]   = win;
              m_data[n]  = 4'(wdata >> (win * 4));
              m_ptr[n]   = (win + 1) % 4;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started && !reset) begin
        for (int n = 0; n < 2; n++) begin
          logic [3:0] eg, ea;
          logic       ee, eb;
          int         off;
          eg = 4'h0; ea = 4'h0; ee = 1'b0; eb = 1'b0;
          if (m_act[n]) begin
            off = cyc - m_start[n];
            if (off <= ocs[n] + 1) begin
              eg = 4'(1 << m_idx[n]);
              eb = 1'b1;
              ee = (off >= 1) && (off <= ocs[n]);
              ea = (off == ocs[n] + 1) ? eg : 4'h0;
            end
          end
          if (n == 0) begin
            chk("model_grant_a", 32'(grant_a), 32'(eg));
            chk("model_ack_a", 32'(ack_a), 32'(ea));
            chk("model_en_a", 32'(latch_en_a), 32'(ee));
            chk("model_d_a", 32'(latch_d_a), 32'(m_data[0]));
            chk("model_busy_a", 32'(busy_a), 32'(eb));
          end else begin
            chk("model_grant_b", 32'(grant_b), 32'(eg));
            chk("model_ack_b", 32'(ack_b), 32'(ea));
            chk("model_en_b", 32'(latch_en_b), 32'(ee));
            chk("model_d_b", 32'(latch_d_b), 32'(m_data[1]));
            chk("model_busy_b", 32'(busy_b), 32'(eb));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_busy", 32'({busy_a, busy_b}), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  // Waits for the next grant on the single-cycle instance and follows it to IDLE.
  task automatic wait_a_grant(input logic [3:0] expg, input logic [3:0] expd);
    int n;
    int acks;
    logic [3:0] lastack;
    n = 0; acks = 0; lastack = 4'h0;
    while (grant_a == 4'h0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("seq_grant", 32'(grant_a), 32'(expg));
    chk("seq_data", 32'(latch_d_a), 32'(expd));
    n = 0;
    while (grant_a != 4'h0 && n < 30) begin
      if (ack_a != 4'h0) begin
        acks++;
        lastack = ack_a;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("seq_ack_count", 32'(acks), 32'd1);
    chk("seq_ack_value", 32'(lastack), 32'(expg));
  endtask

  initial begin
    int n;
    int ens;
    int acks;
    logic [3:0] lastack;
    reset = 1'b1; req = 4'h0; wdata = 16'h0; started = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant_a), 32'd0);
    chk("reset_ack", 32'(ack_a), 32'd0);
    chk("reset_en", 32'(latch_en_a), 32'd0);
    chk("reset_d", 32'(latch_d_a), 32'd0);
    chk("reset_busy", 32'(busy_b), 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    started = 1'b1;

    // Single write, one open cycle.
    @(negedge clk); req = 4'b0001; wdata = 16'h000A;
    @(posedge clk); #1;
    chk("single_c1_grant", 32'(grant_a), 32'h1);
    chk("single_c1_d", 32'(latch_d_a), 32'hA);
    chk("single_c1_en", 32'(latch_en_a), 32'd0);
    chk("single_c1_busy", 32'(busy_a), 32'd1);
    @(negedge clk); req = 4'h0;
    @(posedge clk); #1;
    chk("single_c2_en", 32'(latch_en_a), 32'd1);
    chk("single_c2_grant", 32'(grant_a), 32'h1);
    @(posedge clk); #1;
    chk("single_c3_ack", 32'(ack_a), 32'h1);
    chk("single_c3_en", 32'(latch_en_a), 32'd0);
    chk("single_c3_d", 32'(latch_d_a), 32'hA);
    chk("single_latch_model", 32'(lat_a), 32'hA);
    @(posedge clk); #1;
    chk("single_c4_grant", 32'(grant_a), 32'd0);
    chk("single_c4_busy", 32'(busy_a), 32'd0);
    wait_idle();

    // Round robin with all requests held.
    pulse_reset();
    @(negedge clk); req = 4'b1111; wdata = 16'h4321;
    for (int t = 0; t < 5; t++) wait_a_grant(rr_g[t], rr_d[t]);
    @(negedge clk); req = 4'h0;
    wait_idle();

    // Data stability on the four-cycle instance.
    @(negedge clk); req = 4'b0100; wdata = 16'h0500;
    @(posedge clk); #1;
    n = 0; ens = 0;
    while (grant_b != 4'h0 && n < 30) begin
      chk("stab_d", 32'(latch_d_b), 32'h5);
      if (latch_en_b) ens++;
      @(negedge clk); req = 4'h0; wdata[11:8] = 4'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("stab_en_cycles", 32'(ens), 32'd4);
    wait_idle();

    // Reset while the latch is open.
    @(negedge clk); req = 4'b0001; wdata = 16'h000C;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("midrst_pre_en", 32'(latch_en_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_en_a", 32'(latch_en_a), 32'd0);
    chk("midrst_grant_a", 32'(grant_a), 32'd0);
    chk("midrst_ack_a", 32'(ack_a), 32'd0);
    chk("midrst_en_b", 32'(latch_en_b), 32'd0);
    chk("midrst_grant_b", 32'(grant_b), 32'd0);
    req = 4'b1100; wdata = 16'h9800;
    @(posedge clk); #3;
    reset = 1'b0;
    wait_a_grant(4'b0100, 4'h8);
    @(negedge clk); req = 4'h0;
    wait_idle();

    // Wrap-around priority after requester 3.
    @(negedge clk); req = 4'b1000; wdata = 16'hB000;
    wait_a_grant(4'b1000, 4'hB);
    @(negedge clk); req = 4'h0;
    wait_idle();
    @(negedge clk); req = 4'b1001; wdata = 16'hD00E;
    wait_a_grant(4'b0001, 4'hE);
    wait_a_grant(4'b1000, 4'hD);
    @(negedge clk); req = 4'h0;
    wait_idle();

    // Request dropped right after grant still completes.
    @(negedge clk); req = 4'b0010; wdata = 16'h0070;
    @(posedge clk); #1;
    chk("drop_grant", 32'(grant_a), 32'h2);
    @(negedge clk); req = 4'h0;
    n = 0; acks = 0; lastack = 4'h0;
    while (grant_a != 4'h0 && n < 30) begin
      if (ack_a != 4'h0) begin
        acks++;
        lastack = ack_a;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("drop_ack_count", 32'(acks), 32'd1);
    chk("drop_ack_value", 32'(lastack), 32'h2);
    chk("drop_busy", 32'(busy_a), 32'd0);
    chk("drop_d", 32'(latch_d_a), 32'h7);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
